// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte stores feed a TX FIFO, STATUS is read combinationally.
// The serialiser pops the FIFO head and can chain frames with no idle gap between them.
//
// state   | meaning
// S_IDLE  | line high, waiting for FIFO data
// S_START | start bit (tx=0)
// S_DATA  | eight data bits, LSB first
// S_STOP  | stop bit (tx=1), may chain straight into the next start bit
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wenable,
  output logic [31:0] mem_rdata,
  output logic        hit,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state, state_d;
  logic [BW-1:0]   baud_cnt, baud_cnt_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [7:0]      shift, shift_d;
  logic            tx_d;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;

  logic [1:0]      offset;
  logic            push_req, push, pop, full, empty, busy, ovf_clr;
  logic            unused_bits;

  assign hit      = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign offset   = mem_addr[3:2];
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign busy     = (state != S_IDLE);
  assign push_req = hit && (offset == 2'd0) && mem_wenable[0];
  assign push     = push_req && !full;
  assign ovf_clr  = hit && (offset == 2'd1) && (|mem_wenable) && mem_wdata[3];
  assign unused_bits = ^{mem_wdata[31:8], mem_wdata[2:0], mem_addr[1:0]};

  always_comb begin
    mem_rdata = '0;
    if (hit && offset == 2'd1) begin
      mem_rdata[0]       = full;
      mem_rdata[1]       = empty;
      mem_rdata[2]       = busy;
      mem_rdata[3]       = overflow;
      mem_rdata[8 +: CW] = count;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  end

  // Full-FIFO pushes are dropped even if a pop frees a slot in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (push_req && full) overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_d    = fifo_mem[rd_ptr];
          state_d    = S_START;
          baud_cnt_d = BAUD_RELOAD;
        end
      end
      S_START: begin
        if (baud_cnt == '0) begin
          state_d    = S_DATA;
          bit_idx_d  = 3'd0;
          baud_cnt_d = BAUD_RELOAD;
        end else begin
          baud_cnt_d = baud_cnt - BW'(1);
        end
      end
      S_DATA: begin
        if (baud_cnt == '0) begin
          baud_cnt_d = BAUD_RELOAD;
          shift_d    = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_d = S_STOP;
          else                 bit_idx_d = bit_idx + 3'd1;
        end else begin
          baud_cnt_d = baud_cnt - BW'(1);
        end
      end
      S_STOP: begin
        if (baud_cnt == '0) begin
          if (!empty) begin
            pop        = 1'b1;
            shift_d    = fifo_mem[rd_ptr];
            state_d    = S_START;
            baud_cnt_d = BAUD_RELOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt - BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx is registered from the next state so the line never glitches.
  always_comb begin
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shift    <= shift_d;
      tx       <= tx_d;
    end
  end

endmodule
